// File: rtl/fp_align_iterative_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_align_iterative_if : operand-in / aligned-pair-out handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface fp_align_iterative_if;
  logic        in_valid;
  logic        in_ready;
  logic        Sa;
  logic        Sb;
  logic [9:0]  ShiftDet;
  logic [4:0]  InputExc;
  logic [30:0] Aout;
  logic [30:0] Bout;
  logic        Opout;
  logic        out_valid;
  logic        out_ready;
  logic        Smax;
  logic        Smin;
  logic [7:0]  Emax;
  logic [23:0] Mmax;
  logic [26:0] Mmin;
  logic        Swapped;
  logic        OpOut;
  logic [4:0]  ExcOut;

  modport master (
    output in_valid, Sa, Sb, ShiftDet, InputExc, Aout, Bout, Opout, out_ready,
    input  in_ready, out_valid, Smax, Smin, Emax, Mmax, Mmin, Swapped, OpOut, ExcOut
  );

  modport slave (
    input  in_valid, Sa, Sb, ShiftDet, InputExc, Aout, Bout, Opout, out_ready,
    output in_ready, out_valid, Smax, Smin, Emax, Mmax, Mmin, Swapped, OpOut, ExcOut
  );
endinterface
`default_nettype wire

// File: rtl/fp_align_iterative.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_align_iterative : orders an FP operand pair and iteratively right-aligns
// the smaller significand with guard/round/sticky.   Rev 1.0
// ---------------------------------------------------------------------------
module fp_align_iterative #(
  parameter int SHIFT_STEP = 1,
  parameter int SAT_LIMIT  = 27
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fp_align_iterative_if.slave bus
);

  localparam logic [4:0] c_STEP = 5'(SHIFT_STEP);
  localparam logic [8:0] c_SAT  = 9'(SAT_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_Smax;
  logic        r_Smin;
  logic [7:0]  r_Emax;
  logic [23:0] r_Mmax;
  logic [26:0] r_Mmin;
  logic        r_Swapped;
  logic        r_OpOut;
  logic [4:0]  r_ExcOut;
  logic [4:0]  r_rem;

  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [23:0] w_sig_a;
  logic [23:0] w_sig_b;
  logic        w_swap;
  logic [7:0]  w_emax;
  logic [7:0]  w_emin;
  logic [23:0] w_sig_max;
  logic [23:0] w_sig_min;
  logic [7:0]  w_ediff;
  logic        w_sat;
  logic        w_exc;
  logic [4:0]  w_shamt;
  logic        w_direct;
  logic [26:0] w_mmin_init;

  logic [4:0]  w_k;
  logic [26:0] w_mask;
  logic        w_lost;
  logic [26:0] w_shifted;
  logic [26:0] w_mmin_next;

  // Zero exponent flushes the significand: denormals are treated as zero.
  assign w_exp_a   = bus.Aout[30:23];
  assign w_exp_b   = bus.Bout[30:23];
  assign w_sig_a   = (|w_exp_a) ? {1'b1, bus.Aout[22:0]} : 24'd0;
  assign w_sig_b   = (|w_exp_b) ? {1'b1, bus.Bout[22:0]} : 24'd0;

  assign w_swap    = bus.Bout > bus.Aout;
  assign w_emax    = w_swap ? w_exp_b : w_exp_a;
  assign w_emin    = w_swap ? w_exp_a : w_exp_b;
  assign w_sig_max = w_swap ? w_sig_b : w_sig_a;
  assign w_sig_min = w_swap ? w_sig_a : w_sig_b;

  assign w_ediff   = w_emax - w_emin;
  assign w_sat     = {1'b0, w_ediff} >= c_SAT;
  assign w_exc     = bus.InputExc[4];
  assign w_shamt   = w_swap ? bus.ShiftDet[9:5] : bus.ShiftDet[4:0];
  assign w_direct  = w_exc | w_sat | (w_shamt == 5'd0);

  // Exceptions take precedence over saturation: the operand passes unshifted.
  assign w_mmin_init = (w_sat && !w_exc) ? {26'd0, |w_sig_min} : {w_sig_min, 3'b000};

  assign w_k         = (r_rem < c_STEP) ? r_rem : c_STEP;
  assign w_mask      = (27'd1 << w_k) - 27'd1;
  assign w_lost      = |(r_Mmin & w_mask);
  assign w_shifted   = r_Mmin >> w_k;
  assign w_mmin_next = {w_shifted[26:1], w_shifted[0] | w_lost | r_Mmin[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_Smax      <= 1'b0;
      r_Smin      <= 1'b0;
      r_Emax      <= 8'd0;
      r_Mmax      <= 24'd0;
      r_Mmin      <= 27'd0;
      r_Swapped   <= 1'b0;
      r_OpOut     <= 1'b0;
      r_ExcOut    <= 5'd0;
      r_rem       <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_Smax     <= w_swap ? bus.Sb : bus.Sa;
            r_Smin     <= w_swap ? bus.Sa : bus.Sb;
            r_Emax     <= w_emax;
            r_Mmax     <= w_sig_max;
            r_Mmin     <= w_mmin_init;
            r_Swapped  <= w_swap;
            r_OpOut    <= bus.Opout;
            r_ExcOut   <= bus.InputExc;
            r_rem      <= w_shamt;
            r_in_ready <= 1'b0;
            if (w_direct) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_Mmin <= w_mmin_next;
          r_rem  <= r_rem - w_k;
          if (r_rem == w_k) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Smax      = r_Smax;
  assign bus.Smin      = r_Smin;
  assign bus.Emax      = r_Emax;
  assign bus.Mmax      = r_Mmax;
  assign bus.Mmin      = r_Mmin;
  assign bus.Swapped   = r_Swapped;
  assign bus.OpOut     = r_OpOut;
  assign bus.ExcOut    = r_ExcOut;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_iterative.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_align_iterative : directed self-checking bench for fp_align_iterative
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fp_align_iterative;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  fp_align_iterative_if if1 ();
  fp_align_iterative_if if4 ();

  fp_align_iterative #(.SHIFT_STEP(1), .SAT_LIMIT(27)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  fp_align_iterative #(.SHIFT_STEP(4), .SAT_LIMIT(27)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive1(input logic [30:0] a, input logic [30:0] b, input logic sa,
                        input logic sb, input logic [9:0] sd, input logic [4:0] exc,
                        input logic op);
    if1.Aout = a; if1.Bout = b; if1.Sa = sa; if1.Sb = sb;
    if1.ShiftDet = sd; if1.InputExc = exc; if1.Opout = op;
    if1.in_valid = 1'b1;
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
  endtask

  // Returns 1 when out_valid is already high right after the capture edge.
  task automatic wait_valid1(output int n);
    n = 1;
    while (!if1.out_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release1;
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", if1.in_ready); end
    vectors++; if (if1.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", if1.out_valid); end
    vectors++; if (if1.Mmin !== 27'd0) begin miscompares++; $display("FAIL reset_Mmin: got %h expected 0", if1.Mmin); end
    vectors++; if (if1.Emax !== 8'd0) begin miscompares++; $display("FAIL reset_Emax: got %h expected 0", if1.Emax); end
  endtask

  task automatic test_basic_shift;
    int n;
    drive1(31'h3F800000, 31'h3E800000, 1'b0, 1'b0, 10'h3C2, 5'b00000, 1'b0);
    wait_valid1(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL basic_latency: got %0d expected 3", n); end
    vectors++; if (if1.Swapped !== 1'b0) begin miscompares++; $display("FAIL basic_Swapped: got %b expected 0", if1.Swapped); end
    vectors++; if (if1.Emax !== 8'h7F) begin miscompares++; $display("FAIL basic_Emax: got %h expected 7f", if1.Emax); end
    vectors++; if (if1.Mmax !== 24'h800000) begin miscompares++; $display("FAIL basic_Mmax: got %h expected 800000", if1.Mmax); end
    vectors++; if (if1.Mmin !== 27'h1000000) begin miscompares++; $display("FAIL basic_Mmin: got %h expected 1000000", if1.Mmin); end
    release1();
    vectors++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_return_idle: got ready=%b valid=%b expected 1/0", if1.in_ready, if1.out_valid); end
  endtask

  task automatic test_swap;
    int n;
    drive1(31'h3E800000, 31'h3F800000, 1'b0, 1'b1, 10'h05E, 5'b00000, 1'b1);
    wait_valid1(n);
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL swap_latency: got %0d expected 3", n); end
    vectors++; if (if1.Swapped !== 1'b1) begin miscompares++; $display("FAIL swap_Swapped: got %b expected 1", if1.Swapped); end
    vectors++; if (if1.Mmin !== 27'h1000000) begin miscompares++; $display("FAIL swap_Mmin: got %h expected 1000000", if1.Mmin); end
    vectors++; if (if1.Smax !== 1'b1 || if1.Smin !== 1'b0) begin miscompares++; $display("FAIL swap_signs: got Smax=%b Smin=%b expected 1/0", if1.Smax, if1.Smin); end
    vectors++; if (if1.Emax !== 8'h7F) begin miscompares++; $display("FAIL swap_Emax: got %h expected 7f", if1.Emax); end
    vectors++; if (if1.OpOut !== 1'b1) begin miscompares++; $display("FAIL swap_OpOut: got %b expected 1", if1.OpOut); end
    release1();
  endtask

  task automatic test_sticky;
    int n;
    drive1(31'h3F800000, 31'h3D800001, 1'b0, 1'b0, 10'h384, 5'b00000, 1'b0);
    wait_valid1(n);
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL sticky1_latency: got %0d expected 5", n); end
    vectors++; if (if1.Mmin !== 27'h0400001) begin miscompares++; $display("FAIL sticky1_Mmin: got %h expected 0400001", if1.Mmin); end
    release1();

    if4.Aout = 31'h3F800000; if4.Bout = 31'h3D800001; if4.Sa = 1'b0; if4.Sb = 1'b0;
    if4.ShiftDet = 10'h384; if4.InputExc = 5'b00000; if4.Opout = 1'b0;
    if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    n = 1;
    while (!if4.out_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL sticky4_latency: got %0d expected 2", n); end
    vectors++; if (if4.Mmin !== 27'h0400001) begin miscompares++; $display("FAIL sticky4_Mmin: got %h expected 0400001", if4.Mmin); end
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
    vectors++; if (if4.in_ready !== 1'b1) begin miscompares++; $display("FAIL sticky4_return_idle: got %b expected 1", if4.in_ready); end
  endtask

  task automatic test_saturation;
    int n;
    drive1(31'h3F800000, 31'h30800000, 1'b0, 1'b0, 10'h05E, 5'b00000, 1'b0);
    wait_valid1(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL sat_latency: got %0d expected 1", n); end
    vectors++; if (if1.Mmin !== 27'h0000001) begin miscompares++; $display("FAIL sat_Mmin: got %h expected 0000001", if1.Mmin); end
    vectors++; if (if1.Swapped !== 1'b0 || if1.Emax !== 8'h7F) begin miscompares++; $display("FAIL sat_order: got Swapped=%b Emax=%h expected 0/7f", if1.Swapped, if1.Emax); end
    release1();
  endtask

  task automatic test_exception_hold;
    int n;
    drive1(31'h7F800000, 31'h3F800000, 1'b0, 1'b0, 10'h000, 5'b10010, 1'b0);
    wait_valid1(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL exc_latency: got %0d expected 1", n); end
    vectors++; if (if1.ExcOut !== 5'b10010) begin miscompares++; $display("FAIL exc_ExcOut: got %b expected 10010", if1.ExcOut); end
    vectors++; if (if1.Mmin !== 27'h4000000) begin miscompares++; $display("FAIL exc_Mmin: got %h expected 4000000", if1.Mmin); end
    vectors++; if (if1.Emax !== 8'hFF) begin miscompares++; $display("FAIL exc_Emax: got %h expected ff", if1.Emax); end
    // A competing pair offered while busy must not disturb the held result.
    if1.Aout = 31'h3E800000; if1.Bout = 31'h40000000; if1.ShiftDet = 10'h3FF;
    if1.InputExc = 5'b00000; if1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++; if (if1.in_ready !== 1'b0 || if1.out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_flags[%0d]: got ready=%b valid=%b expected 0/1", i, if1.in_ready, if1.out_valid); end
      vectors++; if (if1.Mmin !== 27'h4000000 || if1.ExcOut !== 5'b10010 || if1.Emax !== 8'hFF) begin miscompares++; $display("FAIL hold_data[%0d]: got Mmin=%h Exc=%b Emax=%h expected 4000000/10010/ff", i, if1.Mmin, if1.ExcOut, if1.Emax); end
    end
    if1.in_valid = 1'b0;
    release1();
    vectors++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0) begin miscompares++; $display("FAIL exc_return_idle: got ready=%b valid=%b expected 1/0", if1.in_ready, if1.out_valid); end
  endtask

  task automatic test_reset_mid_shift;
    int n;
    drive1(31'h3F800000, 31'h3E800000, 1'b0, 1'b0, 10'h3C2, 5'b00000, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    vectors++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_flags: got valid=%b ready=%b expected 0/1", if1.out_valid, if1.in_ready); end
    vectors++; if (if1.Mmin !== 27'd0) begin miscompares++; $display("FAIL midreset_Mmin: got %h expected 0", if1.Mmin); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    drive1(31'h40000000, 31'h40000000, 1'b0, 1'b0, 10'h000, 5'b00000, 1'b0);
    wait_valid1(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL equal_latency: got %0d expected 1", n); end
    vectors++; if (if1.Swapped !== 1'b0) begin miscompares++; $display("FAIL equal_Swapped: got %b expected 0", if1.Swapped); end
    vectors++; if (if1.Mmin !== 27'h4000000) begin miscompares++; $display("FAIL equal_Mmin: got %h expected 4000000", if1.Mmin); end
    vectors++; if (if1.Emax !== 8'h80 || if1.Mmax !== 24'h800000) begin miscompares++; $display("FAIL equal_max: got Emax=%h Mmax=%h expected 80/800000", if1.Emax, if1.Mmax); end
    release1();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.Sa = 1'b0; if1.Sb = 1'b0;
    if1.ShiftDet = 10'd0; if1.InputExc = 5'd0; if1.Aout = 31'd0; if1.Bout = 31'd0; if1.Opout = 1'b0;
    if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.Sa = 1'b0; if4.Sb = 1'b0;
    if4.ShiftDet = 10'd0; if4.InputExc = 5'd0; if4.Aout = 31'd0; if4.Bout = 31'd0; if4.Opout = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic_shift();
    test_swap();
    test_sticky();
    test_saturation();
    test_exception_hold();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
